// File: rtl/trng_harvester_pkg.sv
// Shared FSM encodings and counter-width helpers for the entropy harvester.
package trng_harvester_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FORCE   = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_SAMPLE  = 2'd3;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/entropy_cell.sv
// Cross-coupled NAND latch held at Q=Qn=1 while excite=0; releasing excite lets it resolve metastably.
// The latch output is brought into the clk domain through a 2-flop synchroniser (sync_q lags 2 cycles).
module entropy_cell #(
  parameter bit SIM_MODEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic excite,
  output logic sync_q
);

  logic latch_q;
  logic meta_q;
  logic meta_d;
  logic sync_d;

  if (SIM_MODEL) begin : g_model
    // Behavioural stand-in: contributes a constant 0 so the combined bit is set from outside.
    assign latch_q = excite & 1'b0;
  end else begin : g_latch
    (* dont_touch = "true" *) logic nand_q;
    (* dont_touch = "true" *) logic nand_qn;
    assign nand_q  = ~(excite & nand_qn);
    assign nand_qn = ~(excite & nand_q);
    assign latch_q = nand_q;
  end

  always_comb begin
    meta_d = latch_q;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/trng_harvester.sv
// TRNG harvester: cycles N_SRC entropy cells, XORs their bits, runs a repetition health test,
// von Neumann debiases and packs WIDTH-bit words onto a valid/ready stream (one raw bit per SETTLE+2 cycles).
module trng_harvester
  import trng_harvester_pkg::*;
#(
  parameter int N_SRC     = 8,
  parameter int WIDTH     = 16,
  parameter int SETTLE    = 4,
  parameter int REP_LIMIT = 32,
  parameter bit SIM_MODEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             alarm_clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             alarm,
  output logic             raw_bit,
  output logic             raw_strobe
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int SET_W = cnt_w(SETTLE);
  localparam int REP_W = cnt_w(REP_LIMIT);

  logic [1:0]       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             excite_q, excite_d;
  logic             raw_bit_q, raw_bit_d;
  logic             raw_strobe_q, raw_strobe_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             alarm_q, alarm_d;
  logic             pair_q, pair_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [N_SRC-1:0] src_q;
  logic             xor_bit;
  logic             sample;
  logic             take;
  logic             emit;
  logic             full_q;
  logic             stall;

  for (genvar i = 0; i < N_SRC; i++) begin : g_cell
    (* dont_touch = "true" *) entropy_cell #(
      .SIM_MODEL(SIM_MODEL)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .excite(excite_q),
      .sync_q(src_q[i])
    );
  end

  assign xor_bit = ^src_q;
  assign full_q  = (count_q == CNT_W'(WIDTH));
  // A finished word is parked in the shift register until the output register frees up.
  assign stall   = out_valid_q & full_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sample   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !stall) state_d = ST_FORCE;
      end
      ST_FORCE: begin
        state_d  = ST_RESOLVE;
        settle_d = '0;
      end
      ST_RESOLVE: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d = ST_SAMPLE;
          sample  = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        state_d = (en && !stall) ? ST_FORCE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    excite_d = (state_d == ST_RESOLVE);
  end

  // Health test: the raw bit is captured on the edge that enters SAMPLE, so strobe and alarm rise together.
  always_comb begin
    raw_bit_d    = raw_bit_q;
    raw_strobe_d = sample;
    rep_d        = rep_q;
    alarm_d      = alarm_q;
    take         = 1'b0;
    if (sample) begin
      raw_bit_d = xor_bit;
      if (xor_bit == raw_bit_q) begin
        if (rep_q != REP_W'(REP_LIMIT)) rep_d = rep_q + 1'b1;
      end else begin
        rep_d = REP_W'(1);
      end
      if (rep_d == REP_W'(REP_LIMIT)) alarm_d = 1'b1;
      take = !alarm_q;
    end
    if (alarm_clr) begin
      alarm_d = 1'b0;
      rep_d   = '0;
    end
  end

  // Von Neumann pairing: first bit of a differing pair is the emitted bit (10 -> 1, 01 -> 0).
  always_comb begin
    pair_d  = pair_q;
    first_d = first_q;
    emit    = 1'b0;
    if (take) begin
      pair_d = ~pair_q;
      if (!pair_q) begin
        first_d = xor_bit;
      end else if (first_q != xor_bit) begin
        emit = 1'b1;
      end
    end
  end

  always_comb begin
    shift_d     = shift_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (emit) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (CNT_W'(i) == count_q) shift_d[i] = first_q;
      end
      count_d = count_q + 1'b1;
    end
    // Loading wins over a same-cycle handshake, so valid stays high with the fresh word.
    if ((count_d == CNT_W'(WIDTH)) && (!out_valid_q || out_ready)) begin
      out_data_d  = shift_d;
      out_valid_d = 1'b1;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      excite_q     <= 1'b0;
      raw_bit_q    <= 1'b0;
      raw_strobe_q <= 1'b0;
      rep_q        <= '0;
      alarm_q      <= 1'b0;
      pair_q       <= 1'b0;
      first_q      <= 1'b0;
      shift_q      <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      excite_q     <= excite_d;
      raw_bit_q    <= raw_bit_d;
      raw_strobe_q <= raw_strobe_d;
      rep_q        <= rep_d;
      alarm_q      <= alarm_d;
      pair_q       <= pair_d;
      first_q      <= first_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign alarm      = alarm_q;
  assign raw_bit    = raw_bit_q;
  assign raw_strobe = raw_strobe_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Directed bench for trng_harvester: the combined source bit is scripted by forcing the synchronised cell vector.
module tb_trng_harvester;
  import trng_harvester_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        alarm_clr = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        alarm;
  logic        raw_bit;
  logic        raw_strobe;
  logic [7:0]  src_drive = 8'h81;

  int checks = 0;
  int passes = 0;

  trng_harvester #(
    .N_SRC(8), .WIDTH(16), .SETTLE(4), .REP_LIMIT(32), .SIM_MODEL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .alarm_clr(alarm_clr), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .alarm(alarm), .raw_bit(raw_bit),
    .raw_strobe(raw_strobe)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    en = 1'b0; alarm_clr = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one raw bit (odd/even parity vectors) and wait for the strobe that samples it.
  task automatic feed(input logic b);
    int n;
    src_drive = b ? 8'h07 : 8'h81;
    force dut.src_q = src_drive;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (raw_strobe !== 1'b1 && n < 200);
    if (raw_strobe !== 1'b1) begin
      checks++;
      $display("FAIL strobe_timeout raw_strobe=%b after %0d cycles, want 1", raw_strobe, n);
    end
  endtask

  task automatic feed_seq(input logic [63:0] bits, input int n);
    logic [63:0] v;
    v = bits;
    for (int i = 0; i < n; i++) feed(v[i]);
  endtask

  task automatic test_reset;
    force dut.src_q = src_drive;
    do_reset();
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else passes++;
    checks++; if (out_data !== 16'h0000) $display("FAIL rst_data got %h want 0000", out_data); else passes++;
    checks++; if (alarm !== 1'b0) $display("FAIL rst_alarm got %b want 0", alarm); else passes++;
    checks++; if (raw_bit !== 1'b0) $display("FAIL rst_raw_bit got %b want 0", raw_bit); else passes++;
    checks++; if (raw_strobe !== 1'b0) $display("FAIL rst_strobe got %b want 0", raw_strobe); else passes++;
    checks++; if (dut.excite_q !== 1'b0) $display("FAIL rst_excite got %b want 0", dut.excite_q); else passes++;
  endtask

  task automatic test_en_gate;
    int strobes;
    int excites;
    int first_at;
    int gap;
    strobes = 0; excites = 0;
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (raw_strobe !== 1'b0) strobes++;
      if (dut.excite_q !== 1'b0) excites++;
    end
    checks++; if (strobes != 0) $display("FAIL en0_strobe got %0d pulses want 0", strobes); else passes++;
    checks++; if (excites != 0) $display("FAIL en0_excite got %0d cycles high want 0", excites); else passes++;
    en = 1'b1;
    first_at = 0;
    do begin @(negedge clk); first_at++; end while (raw_strobe !== 1'b1 && first_at < 50);
    checks++; if (first_at != 6) $display("FAIL first_strobe got %0d cycles want 6", first_at); else passes++;
    gap = 0;
    do begin @(negedge clk); gap++; end while (raw_strobe !== 1'b1 && gap < 50);
    checks++; if (gap != 6) $display("FAIL strobe_period got %0d cycles want 6", gap); else passes++;
    en = 1'b0;
  endtask

  task automatic test_pack;
    do_reset();
    en = 1'b1;
    feed_seq(64'h9999_9999_9999_9999, 31);
    checks++; if (out_valid !== 1'b0) $display("FAIL pack_early_valid got %b want 0", out_valid); else passes++;
    feed(1'b1);
    checks++; if (out_valid !== 1'b1) $display("FAIL pack_valid got %b want 1", out_valid); else passes++;
    checks++; if (out_data !== 16'h5555) $display("FAIL pack_data got %h want 5555", out_data); else passes++;
  endtask

  task automatic test_reset_mid;
    feed_seq(64'h19, 5);
    repeat (3) @(negedge clk);
    checks++; if (dut.state_q !== ST_RESOLVE) $display("FAIL mid_state got %0d want %0d", dut.state_q, ST_RESOLVE); else passes++;
    checks++; if (dut.count_q !== 5'd2) $display("FAIL mid_count got %0d want 2", dut.count_q); else passes++;
    checks++; if (dut.excite_q !== 1'b1) $display("FAIL mid_excite got %b want 1", dut.excite_q); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid); else passes++;
    checks++; if (out_data !== 16'h0000) $display("FAIL mid_rst_data got %h want 0000", out_data); else passes++;
    checks++; if (raw_bit !== 1'b0) $display("FAIL mid_rst_raw_bit got %b want 0", raw_bit); else passes++;
    checks++; if (dut.count_q !== 5'd0) $display("FAIL mid_rst_count got %0d want 0", dut.count_q); else passes++;
    checks++; if (dut.excite_q !== 1'b0) $display("FAIL mid_rst_excite got %b want 0", dut.excite_q); else passes++;
    checks++; if (dut.state_q !== ST_IDLE) $display("FAIL mid_rst_state got %0d want %0d", dut.state_q, ST_IDLE); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    feed_seq(64'h6666_6666_6666_6666, 31);
    checks++; if (out_valid !== 1'b0) $display("FAIL post_rst_early_valid got %b want 0", out_valid); else passes++;
    feed(1'b0);
    checks++; if (out_valid !== 1'b1) $display("FAIL post_rst_valid got %b want 1", out_valid); else passes++;
    checks++; if (out_data !== 16'hAAAA) $display("FAIL post_rst_data got %h want aaaa", out_data); else passes++;
  endtask

  task automatic test_discard;
    do_reset();
    en = 1'b1;
    feed_seq(64'hCCCC_CCCC_CCCC_CCCC, 40);
    checks++; if (out_valid !== 1'b0) $display("FAIL disc_valid got %b want 0", out_valid); else passes++;
    checks++; if (dut.count_q !== 5'd0) $display("FAIL disc_count got %0d want 0", dut.count_q); else passes++;
    checks++; if (alarm !== 1'b0) $display("FAIL disc_alarm got %b want 0", alarm); else passes++;
  endtask

  task automatic test_alarm;
    do_reset();
    en = 1'b1;
    feed_seq(64'hFFFF_FFFF_FFFF_FFFF, 31);
    checks++; if (alarm !== 1'b0) $display("FAIL alarm_31 got %b want 0", alarm); else passes++;
    feed(1'b1);
    checks++; if (alarm !== 1'b1) $display("FAIL alarm_32 got %b want 1", alarm); else passes++;
    feed_seq(64'h9, 4);
    checks++; if (dut.count_q !== 5'd0) $display("FAIL alarm_discard_count got %0d want 0", dut.count_q); else passes++;
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    checks++; if (alarm !== 1'b0) $display("FAIL alarm_clr got %b want 0", alarm); else passes++;
    feed_seq(64'h1, 2);
    checks++; if (dut.count_q !== 5'd1) $display("FAIL alarm_resume_count got %0d want 1", dut.count_q); else passes++;
    alarm_clr = 1'b1;
    feed_seq(64'hFFFF_FFFF_FFFF_FFFF, 33);
    checks++; if (alarm !== 1'b0) $display("FAIL alarm_clr_wins got %b want 0", alarm); else passes++;
    @(negedge clk);
    alarm_clr = 1'b0;
    feed_seq(64'hFFFF_FFFF_FFFF_FFFF, 31);
    checks++; if (alarm !== 1'b0) $display("FAIL alarm_rerun_31 got %b want 0", alarm); else passes++;
    feed(1'b1);
    checks++; if (alarm !== 1'b1) $display("FAIL alarm_rerun_32 got %b want 1", alarm); else passes++;
  endtask

  task automatic test_backpressure;
    int strobes;
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    feed_seq(64'h9999_9999_9999_9999, 32);
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_first_valid got %b want 1", out_valid); else passes++;
    feed_seq(64'h6666_6666_6666_6666, 32);
    checks++; if (out_data !== 16'h5555) $display("FAIL bp_held_data got %h want 5555", out_data); else passes++;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (raw_strobe !== 1'b0) strobes++;
    end
    checks++; if (strobes != 0) $display("FAIL bp_stall_strobes got %0d want 0", strobes); else passes++;
    checks++; if (dut.state_q !== ST_IDLE) $display("FAIL bp_stall_state got %0d want %0d", dut.state_q, ST_IDLE); else passes++;
    checks++; if (out_data !== 16'h5555) $display("FAIL bp_stall_data got %h want 5555", out_data); else passes++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_second_valid got %b want 1", out_valid); else passes++;
    checks++; if (out_data !== 16'hAAAA) $display("FAIL bp_second_data got %h want aaaa", out_data); else passes++;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained_valid got %b want 0", out_valid); else passes++;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (raw_strobe === 1'b1) strobes++;
    end
    checks++; if (strobes != 2) $display("FAIL bp_resume_strobes got %0d want 2", strobes); else passes++;
  endtask

  initial begin
    test_reset();
    test_en_gate();
    test_pack();
    test_reset_mid();
    test_discard();
    test_alarm();
    test_backpressure();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
